// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Program-counter owner and IF stage.
//            - Drives the instruction-memory address.
//            - Captures fetched words into the IF/ID register.
//            - Applies stalls and branch redirects, flushing one wrong-path word.
//            - Halts on request or when fetch runs past the populated memory.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        HaltReq,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [15:0] FetchCount
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // The low two bits of the reset PC are dropped so the PC is always word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  // One bit wider than a word index so that IMEM_WORDS = 2^30 still compares sensibly.
  localparam logic [30:0] IMEM_LIMIT       = 31'(IMEM_WORDS);
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [15:0] COUNT_MAX        = 16'hFFFF;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;
  logic        pc_out_of_range;
  logic [31:0] branch_pc;

  // Branch target bits [1:0] are discarded by design: a redirect always lands on a word.
  logic        unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^BranchTarget[1:0];

  assign pc_plus4        = pc_q + 32'd4;
  assign pc_out_of_range = ({1'b0, pc_q[31:2]} >= IMEM_LIMIT);
  assign branch_pc       = {BranchTarget[31:2], 2'b00};

  // State register; reset wins over every other input in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: HALTED is absorbing and only Reset leaves it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (Run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (HaltReq) begin
          state_d = ST_HALTED;
        end else if (BranchTaken || Stall) begin
          state_d = ST_FETCH;
        end else if (pc_out_of_range) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values, following the FETCH priority halt > branch > stall > range > fetch.
  always_comb begin
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc4_d    = ifid_pc4_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (state_q == ST_FETCH) begin
      if (HaltReq) begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end else if (BranchTaken) begin
        // Redirect and squash whatever word sat at the old PC.
        pc_d         = branch_pc;
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end else if (Stall) begin
        pc_d = pc_q;
      end else if (pc_out_of_range) begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_instr_d = IMemInstruction;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
        pc_d         = pc_plus4;
        if (fetch_count_q != COUNT_MAX) begin
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
    end
  end

  // Datapath registers: PC, IF/ID pipeline register and delivered-instruction counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q          <= RESET_PC_ALIGNED;
      ifid_instr_q  <= NOP_WORD;
      ifid_pc4_q    <= 32'd0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      pc_q          <= pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc4_q    <= ifid_pc4_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Output decode: memory address follows the PC combinationally.
  always_comb begin
    IMemAddress      = pc_q;
    IFID_Instruction = ifid_instr_q;
    IFID_PCPlus4     = ifid_pc4_q;
    IFID_Valid       = ifid_valid_q;
    FetchCount       = fetch_count_q;
    Halted           = (state_q == ST_HALTED);
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Brief    : Scenario tasks plus a randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, halt_req, stall, br;
  logic [31:0] tgt;
  logic [31:0] mem [128];

  logic [31:0] addr, ins_in, ins, pc4;
  logic        valid, halted;
  logic [15:0] cnt;

  logic [31:0] hi_addr, hi_ins_in, hi_ins, hi_pc4;
  logic        hi_valid, hi_halted;
  logic [15:0] hi_cnt;

  assign ins_in    = mem[addr[8:2]];
  assign hi_ins_in = mem[hi_addr[8:2]];

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(128)) dut (
    .Clk(clk), .Reset(rst), .Run(run), .HaltReq(halt_req), .Stall(stall),
    .BranchTaken(br), .BranchTarget(tgt), .IMemAddress(addr),
    .IMemInstruction(ins_in), .IFID_Instruction(ins), .IFID_PCPlus4(pc4),
    .IFID_Valid(valid), .Halted(halted), .FetchCount(cnt)
  );

  fetch_sequencer #(.RESET_PC(32'h0000_01F8), .IMEM_WORDS(128)) dut_hi (
    .Clk(clk), .Reset(rst), .Run(run), .HaltReq(halt_req), .Stall(stall),
    .BranchTaken(br), .BranchTarget(tgt), .IMemAddress(hi_addr),
    .IMemInstruction(hi_ins_in), .IFID_Instruction(hi_ins), .IFID_PCPlus4(hi_pc4),
    .IFID_Valid(hi_valid), .Halted(hi_halted), .FetchCount(hi_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model of the main instance (RESET_PC = 0, 128 words).
  logic [31:0] m_pc, m_ins, m_pc4;
  logic        m_v, m_running, m_halted;
  logic [15:0] m_cnt;

  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_ins = 0; m_pc4 = 0; m_v = 0; m_cnt = 0;
      m_running = 0; m_halted = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (!m_running) begin
      if (run) m_running = 1;
    end else if (halt_req) begin
      m_halted = 1; m_v = 0; m_ins = 0;
    end else if (br) begin
      m_pc = (tgt / 4) * 4; m_ins = 0; m_v = 0;
    end else if (stall) begin
      m_v = m_v;
    end else if ((m_pc / 4) >= 128) begin
      m_halted = 1; m_v = 0; m_ins = 0;
    end else begin
      m_ins = mem[m_pc / 4];
      m_pc4 = m_pc + 4;
      m_v   = 1;
      m_pc  = m_pc + 4;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; run = 0; halt_req = 0; stall = 0; br = 0; tgt = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({addr, ins, pc4, valid, halted, cnt} !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state: got addr=%h ins=%h pc4=%h v=%b h=%b cnt=%0d want all zero",
               addr, ins, pc4, valid, halted, cnt);
    end
    checks++;
    if (hi_addr !== 32'h1F8) begin
      errors++;
      $display("FAIL reset_pc_hi: got %h want 000001f8", hi_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (addr !== 32'h0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: got addr=%h v=%b want 0/0", addr, valid);
      end
    end
  endtask

  task automatic test_sequential();
    run = 1;
    tick();
    run = 0;
    checks++;
    if (valid !== 1'b0 || addr !== 32'h0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL run_transition: got v=%b addr=%h cnt=%0d want 0/0/0", valid, addr, cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ins !== 32'(i * 3) || pc4 !== 32'(4 * (i + 1)) || valid !== 1'b1) begin
        errors++;
        $display("FAIL seq_fetch%0d: got ins=%0d pc4=%h v=%b want ins=%0d pc4=%h v=1",
                 i, ins, pc4, valid, i * 3, 4 * (i + 1));
      end
    end
    checks++;
    if (cnt !== 16'd4 || addr !== 32'h10) begin
      errors++;
      $display("FAIL seq_count: got cnt=%0d addr=%h want 4/00000010", cnt, addr);
    end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (addr !== 32'h10 || ins !== 32'd9 || pc4 !== 32'h10 || cnt !== 16'd4) begin
        errors++;
        $display("FAIL stall_hold: got addr=%h ins=%0d pc4=%h cnt=%0d want 10/9/10/4",
                 addr, ins, pc4, cnt);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (ins !== 32'd12 || valid !== 1'b1 || addr !== 32'h14 || cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_release: got ins=%0d v=%b addr=%h cnt=%0d want 12/1/14/5",
               ins, valid, addr, cnt);
    end
  endtask

  task automatic test_branch();
    br = 1; tgt = 32'h48; stall = 1;
    tick();
    br = 0; stall = 0;
    checks++;
    if (addr !== 32'h48 || valid !== 1'b0 || ins !== 32'h0) begin
      errors++;
      $display("FAIL branch_flush: got addr=%h v=%b ins=%h want 48/0/0", addr, valid, ins);
    end
    tick();
    checks++;
    if (ins !== 32'd54 || valid !== 1'b1 || pc4 !== 32'h4C || cnt !== 16'd6) begin
      errors++;
      $display("FAIL branch_target: got ins=%0d v=%b pc4=%h cnt=%0d want 54/1/4c/6",
               ins, valid, pc4, cnt);
    end
  endtask

  task automatic test_misaligned();
    br = 1; tgt = 32'h4B;
    tick();
    br = 0;
    checks++;
    if (addr !== 32'h48) begin
      errors++;
      $display("FAIL misaligned_target: got %h want 00000048", addr);
    end
  endtask

  task automatic test_reset_mid();
    stall = 1; br = 1; tgt = 32'h80; rst = 1;
    tick();
    rst = 0; stall = 0; br = 0;
    checks++;
    if ({addr, valid, cnt, halted} !== {32'h0, 1'b0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got addr=%h v=%b cnt=%0d h=%b want 0/0/0/0", addr, valid, cnt, halted);
    end
    tick(); tick();
    checks++;
    if (addr !== 32'h0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_waits_run: got addr=%h v=%b want 0/0", addr, valid);
    end
    run = 1;
    tick();
    run = 0;
    tick();
    checks++;
    if (addr !== 32'h4 || pc4 !== 32'h4 || valid !== 1'b1 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL resume_after_run: got addr=%h pc4=%h v=%b cnt=%0d want 4/4/1/1",
               addr, pc4, valid, cnt);
    end
  endtask

  task automatic test_halt_req();
    logic [31:0] held;
    tick(); tick();
    held = addr;
    halt_req = 1; br = 1; tgt = 32'h100;
    tick();
    halt_req = 0;
    checks++;
    if (halted !== 1'b1 || valid !== 1'b0 || ins !== 32'h0 || addr !== held) begin
      errors++;
      $display("FAIL halt_over_branch: got h=%b v=%b ins=%h addr=%h want 1/0/0/%h",
               halted, valid, ins, addr, held);
    end
    run = 1; stall = 1;
    tick(); tick();
    run = 0; stall = 0; br = 0;
    checks++;
    if (halted !== 1'b1 || addr !== held || cnt !== m_cnt) begin
      errors++;
      $display("FAIL halted_hold: got h=%b addr=%h cnt=%0d want 1/%h/%0d", halted, addr, cnt, held, m_cnt);
    end
  endtask

  task automatic test_end_of_memory();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0; run = 1;
    tick();
    run = 0;
    tick();
    checks++;
    if (hi_ins !== 32'd378 || hi_valid !== 1'b1 || hi_pc4 !== 32'h1FC) begin
      errors++;
      $display("FAIL eom_word126: got ins=%0d v=%b pc4=%h want 378/1/1fc", hi_ins, hi_valid, hi_pc4);
    end
    tick();
    checks++;
    if (hi_ins !== 32'd381 || hi_addr !== 32'h200 || hi_halted !== 1'b0) begin
      errors++;
      $display("FAIL eom_word127: got ins=%0d addr=%h h=%b want 381/200/0", hi_ins, hi_addr, hi_halted);
    end
    tick();
    checks++;
    if (hi_halted !== 1'b1 || hi_valid !== 1'b0 || hi_addr !== 32'h200) begin
      errors++;
      $display("FAIL eom_halt: got h=%b v=%b addr=%h want 1/0/200", hi_halted, hi_valid, hi_addr);
    end
    run = 1; br = 1; tgt = 32'h0;
    for (int i = 0; i < 3; i++) tick();
    idle_inputs();
    checks++;
    if (hi_halted !== 1'b1 || hi_addr !== 32'h200 || hi_cnt !== 16'd2 || hi_valid !== 1'b0) begin
      errors++;
      $display("FAIL eom_ignore: got h=%b addr=%h cnt=%0d v=%b want 1/200/2/0",
               hi_halted, hi_addr, hi_cnt, hi_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 1500; c++) begin
      rst      = (m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0);
      run      = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 199) == 0);
      stall    = ($urandom_range(0, 99) < 30);
      br       = ($urandom_range(0, 99) < 10);
      tgt      = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h220));
      tick();
      checks++;
      if ({addr, ins, pc4, valid, halted, cnt} !== {m_pc, m_ins, m_pc4, m_v, m_halted, m_cnt}) begin
        errors++;
        $display("FAIL random_cycle%0d: got addr=%h ins=%h pc4=%h v=%b h=%b cnt=%0d want addr=%h ins=%h pc4=%h v=%b h=%b cnt=%0d",
                 c, addr, ins, pc4, valid, halted, cnt, m_pc, m_ins, m_pc4, m_v, m_halted, m_cnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'(i * 3);
    idle_inputs();
    m_pc = 0; m_ins = 0; m_pc4 = 0; m_v = 0; m_cnt = 0; m_running = 0; m_halted = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_misaligned();
    test_reset_mid();
    test_halt_req();
    test_end_of_memory();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
